// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: store geometry, PC constants and the IF/ID register layout.
package mips_pkg;
  localparam int NO_INSTR_BYTES = 1024;
  localparam int MEM_CELL_SIZE  = 8;
  localparam int PC_WIDTH       = 32;

  localparam logic [31:0]         NOP_WORD = 32'h0;
  localparam logic [PC_WIDTH-1:0] PC_INC   = PC_WIDTH'(4);

  typedef struct packed {
    logic [31:0]         instr;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic                valid;
  } if_id_t;
endpackage

// File: rtl/instr_word_reader.sv
// Combinational big-endian word read from the byte-wide instruction store.
module instr_word_reader
  import mips_pkg::*;
#(
  parameter int N_BYTES = NO_INSTR_BYTES,
  parameter int CELL_W  = MEM_CELL_SIZE,
  parameter int ADDR_W  = PC_WIDTH
) (
  input  logic [ADDR_W-1:0]              addr,
  input  logic [N_BYTES-1:0][CELL_W-1:0] instr_byte,
  output logic [31:0]                    word,
  output logic                           out_of_range
);
  localparam int IW = $clog2(N_BYTES);

  logic [IW-1:0] i0, i1, i2, i3;

  // One extra bit so addresses near the top of the PC space do not wrap into range.
  assign out_of_range = ({1'b0, addr} + (ADDR_W+1)'(3)) >= (ADDR_W+1)'(N_BYTES);

  assign i0 = addr[IW-1:0];
  assign i1 = i0 + IW'(1);
  assign i2 = i0 + IW'(2);
  assign i3 = i0 + IW'(3);

  always_comb begin
    word = NOP_WORD;
    if (!out_of_range) word = {instr_byte[i0], instr_byte[i1], instr_byte[i2], instr_byte[i3]};
  end
endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, redirect/stall priority, IF/ID register, sticky faults.
module if_fetch_stage #(
  parameter int NO_INSTR_BYTES = mips_pkg::NO_INSTR_BYTES,
  parameter int MEM_CELL_SIZE  = mips_pkg::MEM_CELL_SIZE,
  parameter int PC_WIDTH       = mips_pkg::PC_WIDTH
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NO_INSTR_BYTES-1:0][MEM_CELL_SIZE-1:0] instr_byte,
  input  logic                                     freeze,
  input  logic                                     branch_taken,
  input  logic [PC_WIDTH-1:0]                      branch_target,
  output logic [PC_WIDTH-1:0]                      fetch_pc,
  output logic [31:0]                              if_id_instr,
  output logic [PC_WIDTH-1:0]                      if_id_pc_plus4,
  output logic                                     if_id_valid,
  output logic                                     addr_fault,
  output logic                                     misalign_fault,
  output logic [31:0]                              fetch_count
);
  import mips_pkg::*;

  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_plus4;
  if_id_t              if_id_q, if_id_d;
  logic                addr_fault_q, addr_fault_d;
  logic                misalign_fault_q, misalign_fault_d;
  logic [31:0]         fetch_count_q, fetch_count_d;
  logic [31:0]         rd_word;
  logic                rd_oor;

  instr_word_reader #(
    .N_BYTES(NO_INSTR_BYTES), .CELL_W(MEM_CELL_SIZE), .ADDR_W(PC_WIDTH)
  ) u_reader (
    .addr        (pc_q),
    .instr_byte  (instr_byte),
    .word        (rd_word),
    .out_of_range(rd_oor)
  );

  assign pc_plus4 = pc_q + PC_INC;

  // Redirect beats freeze; freeze beats advance.
  always_comb begin
    pc_d             = pc_q;
    if_id_d          = if_id_q;
    addr_fault_d     = addr_fault_q;
    misalign_fault_d = misalign_fault_q;
    fetch_count_d    = fetch_count_q;
    if (branch_taken) begin
      pc_d          = {branch_target[PC_WIDTH-1:2], 2'b00};
      if_id_d.instr = NOP_WORD;
      if_id_d.valid = 1'b0;
      if (|branch_target[1:0]) misalign_fault_d = 1'b1;
    end else if (!freeze) begin
      pc_d             = pc_plus4;
      if_id_d.instr    = rd_word;
      if_id_d.pc_plus4 = pc_plus4;
      if_id_d.valid    = 1'b1;
      fetch_count_d    = fetch_count_q + 32'd1;
      if (rd_oor) addr_fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q             <= '0;
      if_id_q          <= '0;
      addr_fault_q     <= 1'b0;
      misalign_fault_q <= 1'b0;
      fetch_count_q    <= '0;
    end else begin
      pc_q             <= pc_d;
      if_id_q          <= if_id_d;
      addr_fault_q     <= addr_fault_d;
      misalign_fault_q <= misalign_fault_d;
      fetch_count_q    <= fetch_count_d;
    end
  end

  assign fetch_pc       = pc_q;
  assign if_id_instr    = if_id_q.instr;
  assign if_id_pc_plus4 = if_id_q.pc_plus4;
  assign if_id_valid    = if_id_q.valid;
  assign addr_fault     = addr_fault_q;
  assign misalign_fault = misalign_fault_q;
  assign fetch_count    = fetch_count_q;
endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed plan scenarios plus randomized redirect/stall traffic vs a reference model.
module tb_if_fetch_stage;
  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [1023:0][7:0] mem;
  logic              freeze = 1'b0;
  logic              branch_taken = 1'b0;
  logic [31:0]       branch_target = '0;
  logic [31:0]       fetch_pc, if_id_instr, if_id_pc_plus4, fetch_count;
  logic              if_id_valid, addr_fault, misalign_fault;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid, m_af, m_mf;

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .instr_byte(mem), .freeze(freeze),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .fetch_pc(fetch_pc), .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid), .addr_fault(addr_fault), .misalign_fault(misalign_fault),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    if (longint'(a) + 3 >= 1024) return 32'h0;
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  task automatic model_clear();
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_cnt = 0; m_valid = 0; m_af = 0; m_mf = 0;
  endtask

  task automatic load_plan();
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    {mem[0], mem[1], mem[2], mem[3]}         = 32'h8020000A;
    {mem[4], mem[5], mem[6], mem[7]}         = 32'h04400800;
    {mem[160], mem[161], mem[162], mem[163]} = 32'h94A8FFFC;
    {mem[164], mem[165], mem[166], mem[167]} = 32'h94C80000;
  endtask

  task automatic do_reset();
    branch_taken = 0; freeze = 0; branch_target = 0;
    rst = 0;
    model_clear();
    @(negedge clk);
    rst = 1;
  endtask

  // One clock edge with the given controls; model follows the fetch rules directly.
  task automatic cyc(input logic br, input logic [31:0] tgt, input logic frz);
    branch_taken = br; branch_target = tgt; freeze = frz;
    @(posedge clk); #1;
    if (br) begin
      m_pc = tgt - (tgt % 4); m_instr = 0; m_valid = 0;
      if (tgt % 4 != 0) m_mf = 1;
    end else if (!frz) begin
      if (longint'(m_pc) + 3 >= 1024) m_af = 1;
      m_instr = ref_word(m_pc); m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4; m_cnt = m_cnt + 1;
    end
    branch_taken = 0; freeze = 0;
  endtask

  task automatic test_reset();
    rst = 0; #2;
    n_chk++;
    if ({fetch_pc, if_id_instr, if_id_pc_plus4, if_id_valid, addr_fault, misalign_fault, fetch_count} !== '0) begin
      n_fail++; $display("FAIL reset_state: got pc=%h instr=%h pc4=%h v=%b af=%b mf=%b cnt=%0d want all zero",
        fetch_pc, if_id_instr, if_id_pc_plus4, if_id_valid, addr_fault, misalign_fault, fetch_count);
    end
    do_reset();
  endtask

  task automatic test_fetch();
    do_reset();
    cyc(0, 0, 0);
    n_chk++; if (if_id_instr !== 32'h8020000A) begin n_fail++; $display("FAIL fetch0_instr: got %h want 8020000a", if_id_instr); end
    n_chk++; if (if_id_pc_plus4 !== 32'd4) begin n_fail++; $display("FAIL fetch0_pc4: got %h want 4", if_id_pc_plus4); end
    n_chk++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL fetch0_valid: got %b want 1", if_id_valid); end
    n_chk++; if (fetch_pc !== 32'd4) begin n_fail++; $display("FAIL fetch0_pc: got %h want 4", fetch_pc); end
    cyc(0, 0, 0);
    n_chk++; if (if_id_instr !== 32'h04400800) begin n_fail++; $display("FAIL fetch1_instr: got %h want 04400800", if_id_instr); end
    n_chk++; if (fetch_count !== 32'd2) begin n_fail++; $display("FAIL fetch1_count: got %0d want 2", fetch_count); end
  endtask

  task automatic test_freeze();
    do_reset();
    cyc(0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 1);
      n_chk++; if (if_id_instr !== 32'h8020000A) begin n_fail++; $display("FAIL freeze_instr[%0d]: got %h want 8020000a", k, if_id_instr); end
      n_chk++; if (fetch_pc !== 32'd4) begin n_fail++; $display("FAIL freeze_pc[%0d]: got %h want 4", k, fetch_pc); end
      n_chk++; if (fetch_count !== 32'd1) begin n_fail++; $display("FAIL freeze_count[%0d]: got %0d want 1", k, fetch_count); end
    end
    cyc(0, 0, 0);
    n_chk++; if (if_id_instr !== 32'h04400800) begin n_fail++; $display("FAIL unfreeze_instr: got %h want 04400800", if_id_instr); end
  endtask

  task automatic test_branch();
    cyc(1, 32'hA0, 0);
    n_chk++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL br_valid: got %b want 0", if_id_valid); end
    n_chk++; if (if_id_instr !== 32'h0) begin n_fail++; $display("FAIL br_instr: got %h want 0", if_id_instr); end
    n_chk++; if (fetch_pc !== 32'hA0) begin n_fail++; $display("FAIL br_pc: got %h want a0", fetch_pc); end
    n_chk++; if (if_id_pc_plus4 !== 32'h8) begin n_fail++; $display("FAIL br_pc4_hold: got %h want 8", if_id_pc_plus4); end
    cyc(0, 0, 0);
    n_chk++; if (if_id_instr !== 32'h94A8FFFC) begin n_fail++; $display("FAIL br_tgt_instr: got %h want 94a8fffc", if_id_instr); end
    n_chk++; if (if_id_pc_plus4 !== 32'hA4) begin n_fail++; $display("FAIL br_tgt_pc4: got %h want a4", if_id_pc_plus4); end
    n_chk++; if (misalign_fault !== 1'b0) begin n_fail++; $display("FAIL br_no_misalign: got %b want 0", misalign_fault); end
  endtask

  task automatic test_branch_beats_freeze();
    cyc(1, 32'hA6, 1);
    n_chk++; if (misalign_fault !== 1'b1) begin n_fail++; $display("FAIL bf_misalign: got %b want 1", misalign_fault); end
    n_chk++; if (fetch_pc !== 32'hA4) begin n_fail++; $display("FAIL bf_pc: got %h want a4", fetch_pc); end
    n_chk++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL bf_valid: got %b want 0", if_id_valid); end
    cyc(0, 0, 0);
    n_chk++; if (if_id_instr !== 32'h94C80000) begin n_fail++; $display("FAIL bf_instr: got %h want 94c80000", if_id_instr); end
  endtask

  task automatic test_addr_fault();
    cyc(1, 32'h400, 0);
    n_chk++; if (addr_fault !== 1'b0) begin n_fail++; $display("FAIL af_early: got %b want 0", addr_fault); end
    cyc(0, 0, 0);
    n_chk++; if (if_id_instr !== 32'h0) begin n_fail++; $display("FAIL af_instr: got %h want 0", if_id_instr); end
    n_chk++; if (if_id_valid !== 1'b1) begin n_fail++; $display("FAIL af_valid: got %b want 1", if_id_valid); end
    n_chk++; if (addr_fault !== 1'b1) begin n_fail++; $display("FAIL af_flag: got %b want 1", addr_fault); end
    n_chk++; if (fetch_pc !== 32'h404) begin n_fail++; $display("FAIL af_pc: got %h want 404", fetch_pc); end
    cyc(1, 32'h0, 0);
    cyc(0, 0, 0);
    n_chk++; if (addr_fault !== 1'b1) begin n_fail++; $display("FAIL af_sticky: got %b want 1", addr_fault); end
    n_chk++; if (if_id_instr !== 32'h8020000A) begin n_fail++; $display("FAIL af_recover: got %h want 8020000a", if_id_instr); end
  endtask

  task automatic test_midrun_reset();
    cyc(0, 0, 0);
    cyc(1, 32'h1FE, 0);
    #1 rst = 0;
    #1;
    n_chk++;
    if ({fetch_pc, if_id_instr, if_id_pc_plus4, if_id_valid, addr_fault, misalign_fault, fetch_count} !== '0) begin
      n_fail++; $display("FAIL midrun_reset: got pc=%h instr=%h pc4=%h v=%b af=%b mf=%b cnt=%0d want all zero",
        fetch_pc, if_id_instr, if_id_pc_plus4, if_id_valid, addr_fault, misalign_fault, fetch_count);
    end
    model_clear();
    @(negedge clk); rst = 1;
    cyc(0, 0, 0);
    n_chk++; if (if_id_instr !== 32'h8020000A) begin n_fail++; $display("FAIL post_reset_instr: got %h want 8020000a", if_id_instr); end
    n_chk++; if (fetch_count !== 32'd1) begin n_fail++; $display("FAIL post_reset_count: got %0d want 1", fetch_count); end
  endtask

  task automatic test_random();
    logic        br, frz;
    logic [31:0] tgt;
    load_plan();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      br  = ($urandom_range(0, 7) == 0);
      frz = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0:       tgt = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
        1:       tgt = 32'($urandom_range(1016, 1040));
        default: tgt = 32'($urandom_range(0, 1023));
      endcase
      cyc(br, tgt, frz);
      n_chk++; if (fetch_pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h want %h", n, fetch_pc, m_pc); end
      n_chk++; if (if_id_instr !== m_instr) begin n_fail++; $display("FAIL rnd_instr[%0d]: got %h want %h", n, if_id_instr, m_instr); end
      n_chk++; if (if_id_pc_plus4 !== m_pc4) begin n_fail++; $display("FAIL rnd_pc4[%0d]: got %h want %h", n, if_id_pc_plus4, m_pc4); end
      n_chk++; if (if_id_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, if_id_valid, m_valid); end
      n_chk++; if (addr_fault !== m_af) begin n_fail++; $display("FAIL rnd_af[%0d]: got %b want %b", n, addr_fault, m_af); end
      n_chk++; if (misalign_fault !== m_mf) begin n_fail++; $display("FAIL rnd_mf[%0d]: got %b want %b", n, misalign_fault, m_mf); end
      n_chk++; if (fetch_count !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", n, fetch_count, m_cnt); end
    end
  endtask

  initial begin
    load_plan();
    model_clear();
    test_reset();
    test_fetch();
    test_freeze();
    test_branch();
    test_branch_beats_freeze();
    test_addr_fault();
    test_midrun_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
